// File: rtl/posit_decode_arbiter_if.sv
// Request/response bundle for posit_decode_arbiter: NREQ posit request lanes in,
// one decoded result tagged with its requester index out.
interface posit_decode_arbiter_if #(
  parameter int NREQ = 4,
  parameter int N    = 32
);
  localparam int IDW = $clog2(NREQ);

  typedef logic sign_t;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*N-1:0]  req_posit;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  sign_t              resp_sign;
  logic signed [63:0] resp_regime;
  logic signed [63:0] resp_exponent;
  logic [63:0]        resp_fraction;
  logic               resp_zero;
  logic               resp_nar;

  modport master (
    output req_valid, req_posit, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sign, resp_regime,
           resp_exponent, resp_fraction, resp_zero, resp_nar
  );

  modport slave (
    input  req_valid, req_posit, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sign, resp_regime,
           resp_exponent, resp_fraction, resp_zero, resp_nar
  );
endinterface

// File: rtl/posit_decode_arbiter.sv
// Round-robin arbiter feeding one shared posit decoder through a two-stage
// pipeline (S1 = granted word, S2 = decoded result register).
module posit_decode_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 32,
  parameter int ES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  posit_decode_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] off_sel;
  logic [IDW:0]   sum;
  logic [IDW:0]   nxt;
  logic [NREQ-1:0] rot;
  logic           found;
  logic           stall;
  logic [N-1:0]   sel_posit;

  logic           s1_valid;
  logic [N-1:0]   s1_posit;
  logic [IDW-1:0] s1_id;

  logic               s2_valid;
  logic [IDW-1:0]     s2_id;
  logic               s2_sign;
  logic signed [63:0] s2_regime;
  logic signed [63:0] s2_exponent;
  logic [63:0]        s2_fraction;
  logic               s2_zero;
  logic               s2_nar;

  logic [N-2:0]       body;
  logic [N-2:0]       rest;
  logic [N-2:0]       fbits;
  logic               rbit;
  logic               run_on;
  int                 run_len;
  logic               dec_sign;
  logic               dec_zero;
  logic               dec_nar;
  logic signed [63:0] dec_regime;
  logic signed [63:0] dec_exponent;
  logic [63:0]        dec_fraction;

  assign stall = s2_valid & ~bus.resp_ready;

  // Rotate the valid vector so the search always starts at bit 0, then map
  // the found offset back to a requester index with a wrap at NREQ.
  always_comb begin
    rot     = NREQ'({bus.req_valid, bus.req_valid} >> ptr);
    found   = 1'b0;
    off_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found   = 1'b1;
        off_sel = IDW'(i);
      end
    end
    sum     = {1'b0, ptr} + {1'b0, off_sel};
    gnt     = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
    nxt     = {1'b0, gnt} + 1'b1;
    ptr_nxt = (nxt == NREQ_W) ? '0 : IDW'(nxt);
    sel_posit = N'(bus.req_posit >> (int'(gnt) * N));
  end

  always_comb begin
    bus.req_ready = '0;
    if (found && !stall && !rst) bus.req_ready = NREQ'(1) << gnt;
  end

  // Decoder works on the magnitude below the sign bit; the low N-1 bits of
  // the full two's complement are the negation of the low N-1 bits alone.
  always_comb begin
    dec_zero = (s1_posit == '0);
    dec_nar  = (s1_posit == {1'b1, {(N-1){1'b0}}});
    dec_sign = s1_posit[N-1];
    body     = s1_posit[N-1] ? (~s1_posit[N-2:0] + 1'b1) : s1_posit[N-2:0];
    rbit     = body[N-2];
    run_len  = 0;
    run_on   = 1'b1;
    for (int i = N-2; i >= 0; i--) begin
      if (run_on && (body[i] == rbit)) run_len = run_len + 1;
      else run_on = 1'b0;
    end
    rest         = body << (run_len + 1);
    fbits        = rest << ES;
    dec_regime   = rbit ? 64'(run_len - 1) : -64'(run_len);
    dec_exponent = 64'(rest >> (N - 1 - ES));
    dec_fraction = 64'(fbits) << (65 - N);
    if (dec_zero || dec_nar) begin
      dec_sign     = 1'b0;
      dec_regime   = '0;
      dec_exponent = '0;
      dec_fraction = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_posit <= '0;
      s1_id    <= '0;
    end else if (!stall) begin
      s1_valid <= found;
      if (found) begin
        s1_posit <= sel_posit;
        s1_id    <= gnt;
        ptr      <= ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_id       <= '0;
      s2_sign     <= 1'b0;
      s2_regime   <= '0;
      s2_exponent <= '0;
      s2_fraction <= '0;
      s2_zero     <= 1'b0;
      s2_nar      <= 1'b0;
    end else if (!stall) begin
      s2_valid    <= s1_valid;
      s2_id       <= s1_id;
      s2_sign     <= dec_sign;
      s2_regime   <= dec_regime;
      s2_exponent <= dec_exponent;
      s2_fraction <= dec_fraction;
      s2_zero     <= dec_zero;
      s2_nar      <= dec_nar;
    end
  end

  assign bus.resp_valid    = s2_valid;
  assign bus.resp_id       = s2_id;
  assign bus.resp_sign     = s2_sign;
  assign bus.resp_regime   = s2_regime;
  assign bus.resp_exponent = s2_exponent;
  assign bus.resp_fraction = s2_fraction;
  assign bus.resp_zero     = s2_zero;
  assign bus.resp_nar      = s2_nar;
endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Self-checking bench for posit_decode_arbiter: decode table, latency, fairness,
// backpressure, mid-flight reset, and wrap behaviour of a 3-requester instance.
module tb_posit_decode_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int ES   = 2;
  localparam int NVEC = 14;

  logic clk = 1'b0;
  logic rst;
  logic rst3;

  always #5 clk = ~clk;

  posit_decode_arbiter_if #(.NREQ(NREQ), .N(N)) bus ();
  posit_decode_arbiter #(.NREQ(NREQ), .N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  posit_decode_arbiter_if #(.NREQ(3), .N(N)) bus3 ();
  posit_decode_arbiter #(.NREQ(3), .N(N), .ES(ES)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3.slave)
  );

  typedef struct {
    logic [N-1:0]       posit;
    logic               sign;
    logic signed [63:0] regime;
    logic signed [63:0] exponent;
    logic [63:0]        fraction;
    logic               zero;
    logic               nar;
  } vec_t;

  typedef struct {
    int id;
    int vi;
  } exp_t;

  vec_t vecs[NVEC];
  exp_t sbq[$];
  int   lane_vec[NREQ];
  int   n_checks;
  int   n_fails;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rready);
    bus.req_valid  = valid;
    bus.resp_ready = rready;
    for (int i = 0; i < NREQ; i++) bus.req_posit[i*N +: N] = vecs[lane_vec[i]].posit;
  endtask

  task automatic compareResp(input exp_t e);
    string t;
    t = $sformatf("resp[v%0d]", e.vi);
    checkOutput({t, ".id"},       64'(bus.resp_id),       64'(e.id));
    checkOutput({t, ".sign"},     64'(bus.resp_sign),     64'(vecs[e.vi].sign));
    checkOutput({t, ".regime"},   bus.resp_regime,        vecs[e.vi].regime);
    checkOutput({t, ".exponent"}, bus.resp_exponent,      vecs[e.vi].exponent);
    checkOutput({t, ".fraction"}, bus.resp_fraction,      vecs[e.vi].fraction);
    checkOutput({t, ".zero"},     64'(bus.resp_zero),     64'(vecs[e.vi].zero));
    checkOutput({t, ".nar"},      64'(bus.resp_nar),      64'(vecs[e.vi].nar));
  endtask

  // exp_grant: lane expected to see req_ready, -1 for none, -2 to skip the check
  task automatic clockCycle(input int exp_grant, input string tag);
    logic [NREQ-1:0] exp_ready;
    exp_t e;
    #1;
    if (bus.resp_valid && bus.resp_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s.unexpected_resp: got id %0d, expected no response", tag, bus.resp_id);
      end else begin
        e = sbq.pop_front();
        compareResp(e);
      end
    end
    if (exp_grant != -2) begin
      exp_ready = (exp_grant >= 0) ? (NREQ'(1) << exp_grant) : '0;
      checkOutput({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
    end
    for (int i = 0; i < NREQ; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) sbq.push_back('{id: i, vi: lane_vec[i]});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 10 && sbq.size() > 0; c++) clockCycle(-2, tag);
    clockCycle(-1, tag);
    checkOutput({tag, ".queue_empty"}, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    vecs[0]  = '{32'h40000000, 1'b0,  64'sd0,   64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[1]  = '{32'h48000000, 1'b0,  64'sd0,   64'sd1, 64'h0, 1'b0, 1'b0};
    vecs[2]  = '{32'hC0000000, 1'b1,  64'sd0,   64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000000, 1'b0,  64'sd0,   64'sd0, 64'h0, 1'b1, 1'b0};
    vecs[4]  = '{32'h80000000, 1'b0,  64'sd0,   64'sd0, 64'h0, 1'b0, 1'b1};
    vecs[5]  = '{32'h7FFFFFFF, 1'b0,  64'sd30,  64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000001, 1'b0, -64'sd30,  64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[7]  = '{32'h4C000000, 1'b0,  64'sd0,   64'sd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{32'h60000000, 1'b0,  64'sd1,   64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[9]  = '{32'h3FFFFFFF, 1'b0, -64'sd1,   64'sd3, 64'hFFFF_FFE0_0000_0000, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 1'b1, -64'sd30,  64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[11] = '{32'h7FFFFFFE, 1'b0,  64'sd29,  64'sd0, 64'h0, 1'b0, 1'b0};
    vecs[12] = '{32'h7FFFFFFD, 1'b0,  64'sd28,  64'sd2, 64'h0, 1'b0, 1'b0};
    vecs[13] = '{32'hB8000000, 1'b1,  64'sd0,   64'sd1, 64'h0, 1'b0, 1'b0};
    for (int i = 0; i < NREQ; i++) lane_vec[i] = i;

    rst  = 1'b1;
    rst3 = 1'b1;
    bus3.req_valid  = '0;
    bus3.resp_ready = 1'b1;
    bus3.req_posit  = {3{32'h40000000}};
    applyStimulus('1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset.req_ready",     64'(bus.req_ready),  64'd0);
    checkOutput("reset.resp_valid",    64'(bus.resp_valid), 64'd0);
    checkOutput("reset.resp_id",       64'(bus.resp_id),    64'd0);
    checkOutput("reset.resp_sign",     64'(bus.resp_sign),  64'd0);
    checkOutput("reset.resp_regime",   bus.resp_regime,     64'd0);
    checkOutput("reset.resp_exponent", bus.resp_exponent,   64'd0);
    checkOutput("reset.resp_fraction", bus.resp_fraction,   64'd0);
    checkOutput("reset.resp_zero",     64'(bus.resp_zero),  64'd0);
    checkOutput("reset.resp_nar",      64'(bus.resp_nar),   64'd0);
    rst = 1'b0;

    $display("[TB] single requester latency");
    lane_vec[2] = 0;
    applyStimulus(4'b0100, 1'b1);
    clockCycle(2, "single");
    applyStimulus('0, 1'b1);
    checkOutput("single.cycle1_valid", 64'(bus.resp_valid), 64'd0);
    clockCycle(-1, "single");
    checkOutput("single.cycle2_valid", 64'(bus.resp_valid), 64'd1);
    clockCycle(-1, "single");
    checkOutput("single.queue_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] decode table");
    for (int k = 0; k < NVEC; k++) begin
      lane_vec[k % NREQ] = k;
      applyStimulus(NREQ'(1) << (k % NREQ), 1'b1);
      clockCycle(k % NREQ, $sformatf("vec%0d", k));
    end
    drain("vec");

    $display("[TB] fairness");
    rst = 1'b1;
    applyStimulus('0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) lane_vec[i] = i;
    for (int c = 0; c < 8; c++) begin
      applyStimulus('1, 1'b1);
      clockCycle(c % NREQ, $sformatf("fair%0d", c));
    end

    $display("[TB] backpressure");
    for (int c = 0; c < 3; c++) begin
      applyStimulus('1, 1'b0);
      checkOutput("stall.resp_valid", 64'(bus.resp_valid), 64'd1);
      if (sbq.size() > 0) compareResp(sbq[0]);
      clockCycle(-1, $sformatf("stall%0d", c));
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus('1, 1'b1);
      clockCycle(c % NREQ, $sformatf("release%0d", c));
    end
    drain("release");

    $display("[TB] reset mid-flight");
    applyStimulus('1, 1'b1);
    clockCycle(0, "fill0");
    clockCycle(1, "fill1");
    rst = 1'b1;
    applyStimulus('1, 1'b0);
    #1;
    checkOutput("midrst.req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    sbq.delete();
    checkOutput("midrst.resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("midrst.resp_id",    64'(bus.resp_id),    64'd0);
    rst = 1'b0;
    applyStimulus('1, 1'b1);
    clockCycle(0, "postrst0");
    clockCycle(1, "postrst1");
    drain("postrst");

    $display("[TB] wrap with three requesters");
    rst3 = 1'b0;
    bus3.req_valid = 3'b010;
    #1;
    checkOutput("wrap.grant1", 64'(bus3.req_ready), 64'(3'b010));
    @(posedge clk); #1;
    bus3.req_valid = 3'b101;
    #1;
    checkOutput("wrap.grant2", 64'(bus3.req_ready), 64'(3'b100));
    @(posedge clk); #1;
    #1;
    checkOutput("wrap.grant0", 64'(bus3.req_ready), 64'(3'b001));
    @(posedge clk); #1;
    checkOutput("wrap.resp_valid", 64'(bus3.resp_valid), 64'd1);
    checkOutput("wrap.resp_id2",   64'(bus3.resp_id),    64'd2);
    bus3.req_valid = 3'b111;
    #1;
    checkOutput("wrap.after0", 64'(bus3.req_ready), 64'(3'b010));
    @(posedge clk); #1;
    checkOutput("wrap.resp_id0", 64'(bus3.resp_id), 64'd0);
    bus3.req_valid = '0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
